// File: rtl/mon_status_pkg.sv
// Shared definitions for the board status producer and the LED display controller:
// FSM encodings and the bit positions of the 8-bit status vector.
package mon_status_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } mon_state_e;

  localparam int STATUS_W             = 8;
  localparam int STATUS_RX_PMA_READY  = 0;
  localparam int STATUS_TX_PMA_READY  = 1;
  localparam int STATUS_MON_DONE      = 2;
  localparam int STATUS_MON_ERROR     = 3;
  localparam int STATUS_MON_ACTIVE    = 4;
  localparam int STATUS_RX_DATA_READY = 5;
  localparam int STATUS_TX_DATA_READY = 6;
  localparam int STATUS_SEL_DISPLAY   = 7;

  function automatic logic [STATUS_W-1:0] pack_status(
    input logic sel_display,
    input logic tx_data_ready,
    input logic rx_data_ready,
    input logic mon_active,
    input logic mon_error,
    input logic mon_done,
    input logic tx_pma_ready,
    input logic rx_pma_ready
  );
    logic [STATUS_W-1:0] v;
    v                       = {STATUS_W{1'b0}};
    v[STATUS_SEL_DISPLAY]   = sel_display;
    v[STATUS_TX_DATA_READY] = tx_data_ready;
    v[STATUS_RX_DATA_READY] = rx_data_ready;
    v[STATUS_MON_ACTIVE]    = mon_active;
    v[STATUS_MON_ERROR]     = mon_error;
    v[STATUS_MON_DONE]      = mon_done;
    v[STATUS_TX_PMA_READY]  = tx_pma_ready;
    v[STATUS_RX_PMA_READY]  = rx_pma_ready;
    return v;
  endfunction

endpackage

// File: rtl/mon_status_ctrl_if.sv
// Traffic-checker and status bus between mon_status_ctrl (master) and its consumers (slave).
interface mon_status_ctrl_if #(
  parameter int ERRW = 16
);
  logic            chk_valid;
  logic            chk_error;
  logic            gen_enable;
  logic [ERRW-1:0] err_count;
  logic [31:0]     word_count;
  logic [7:0]      status;

  modport master (
    input  chk_valid,
    input  chk_error,
    output gen_enable,
    output err_count,
    output word_count,
    output status
  );

  modport slave (
    output chk_valid,
    output chk_error,
    input  gen_enable,
    input  err_count,
    input  word_count,
    input  status
  );
endinterface

// File: rtl/mon_status_ctrl_pb_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-level counter and a one-cycle
// press pulse; a new press needs the button released for DEBOUNCE_CYCLES first.
module pb_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pb_n,
  output logic press
);

  logic [1:0]  sync_r;
  logic        pressed_r;
  logic [19:0] cnt_r;
  logic        press_r;
  logic        pb_low_s;
  logic        pressed_nxt_s;
  logic [19:0] cnt_nxt_s;
  logic        press_nxt_s;

  assign pb_low_s = ~sync_r[1];

  // Count cycles the synced level disagrees with the accepted state; flip once it is stable.
  always_comb begin
    pressed_nxt_s = pressed_r;
    cnt_nxt_s     = cnt_r;
    press_nxt_s   = 1'b0;
    if (pressed_r == pb_low_s) begin
      cnt_nxt_s = 20'd0;
    end else if (cnt_r >= DEBOUNCE_CYCLES - 20'd1) begin
      cnt_nxt_s     = 20'd0;
      pressed_nxt_s = pb_low_s;
      press_nxt_s   = pb_low_s;
    end else begin
      cnt_nxt_s = cnt_r + 20'd1;
    end
  end

  // Synchroniser idles high so a released button never looks pressed out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r    <= 2'b11;
      pressed_r <= 1'b0;
      cnt_r     <= 20'd0;
      press_r   <= 1'b0;
    end else begin
      sync_r    <= {sync_r[0], pb_n};
      pressed_r <= pressed_nxt_s;
      cnt_r     <= cnt_nxt_s;
      press_r   <= press_nxt_s;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/mon_status_ctrl.sv
// Board status producer: debounced start/clear, synced PMA flags, timed link-test sequencer.
// Optional ARM-phase timeout is built only when MON_TIMEOUT_EN is defined.
module mon_status_ctrl
  import mon_status_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [31:0] RUN_CYCLES      = 32'd156250000,
  parameter logic [15:0] DRAIN_CYCLES    = 16'd1024,
`ifdef MON_TIMEOUT_EN
  parameter logic [31:0] ARM_TIMEOUT     = 32'd15625000,
`endif
  parameter int          ERRW            = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pb_start_n,
  input  logic              pb_clear_n,
  input  logic              dip_sel_display,
  input  logic              tx_pma_ready_in,
  input  logic              rx_pma_ready_in,
  input  logic              tx_data_ready_in,
  input  logic              rx_data_ready_in,
  mon_status_ctrl_if.master bus
);

  localparam logic [ERRW-1:0] ERR_ONE  = ERRW'(1'b1);
  localparam logic [ERRW-1:0] ERR_ZERO = {ERRW{1'b0}};

  function automatic logic [ERRW-1:0] sat_inc_err(input logic [ERRW-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + ERR_ONE;
    end
  endfunction

  function automatic logic [31:0] sat_inc_word(input logic [31:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  logic [4:0]      meta_r;
  logic [4:0]      sync_r;
  logic            sel_display_s, tx_data_ready_s, rx_data_ready_s;
  logic            tx_pma_ready_s, rx_pma_ready_s, ready_ok_s;
  logic            start_press_s, clear_press_s;

  mon_state_e      state_r, state_nxt_s;
  logic            enter_arm_s, enter_run_s, enter_drain_s, link_loss_s;
  logic            arm_expired_s, count_en_s;

  logic [ERRW-1:0] err_count_r, err_nxt_s;
  logic [31:0]     word_count_r, word_nxt_s;
  logic            link_lost_r, link_lost_nxt_s;
  logic [31:0]     run_cnt_r, run_cnt_nxt_s;
  logic [15:0]     drain_cnt_r, drain_cnt_nxt_s;
  logic            timeout_nxt_s;

  logic            gen_enable_r, mon_active_r, mon_done_r, mon_error_r;

  // Two-flop synchroniser for the DIP switch and all four ready flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 5'd0;
      sync_r <= 5'd0;
    end else begin
      meta_r <= {dip_sel_display, tx_data_ready_in, rx_data_ready_in,
                 tx_pma_ready_in, rx_pma_ready_in};
      sync_r <= meta_r;
    end
  end

  assign sel_display_s   = sync_r[4];
  assign tx_data_ready_s = sync_r[3];
  assign rx_data_ready_s = sync_r[2];
  assign tx_pma_ready_s  = sync_r[1];
  assign rx_pma_ready_s  = sync_r[0];
  assign ready_ok_s      = tx_pma_ready_s & rx_pma_ready_s;

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk     (clk),
    .reset_n (reset_n),
    .pb_n    (pb_start_n),
    .press   (start_press_s)
  );

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk     (clk),
    .reset_n (reset_n),
    .pb_n    (pb_clear_n),
    .press   (clear_press_s)
  );

`ifdef MON_TIMEOUT_EN
  logic [31:0] arm_cnt_r;
  logic        timeout_r;
  logic        timeout_hit_s;

  assign arm_expired_s = (arm_cnt_r >= ARM_TIMEOUT - 32'd1);
  assign timeout_hit_s = (state_r == ST_ARM) & ~ready_ok_s & arm_expired_s & ~clear_press_s;

  // Timeout verdict: cleared on every new arm or clear, set when ARM gives up.
  always_comb begin
    timeout_nxt_s = timeout_r;
    if (clear_press_s || enter_arm_s) begin
      timeout_nxt_s = 1'b0;
    end else if (timeout_hit_s) begin
      timeout_nxt_s = 1'b1;
    end else begin
      timeout_nxt_s = timeout_r;
    end
  end

  // ARM dwell counter, restarted whenever the FSM is not staying in ARM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_r <= 32'd0;
      timeout_r <= 1'b0;
    end else begin
      if ((state_r == ST_ARM) && (state_nxt_s == ST_ARM)) begin
        arm_cnt_r <= arm_cnt_r + 32'd1;
      end else begin
        arm_cnt_r <= 32'd0;
      end
      timeout_r <= timeout_nxt_s;
    end
  end
`else
  assign arm_expired_s = 1'b0;
  assign timeout_nxt_s = 1'b0;
`endif

  // Next-state logic; clear has priority over every transition, including start.
  always_comb begin
    state_nxt_s   = state_r;
    enter_arm_s   = 1'b0;
    enter_run_s   = 1'b0;
    enter_drain_s = 1'b0;
    link_loss_s   = 1'b0;
    if (clear_press_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_press_s) begin
            state_nxt_s = ST_ARM;
            enter_arm_s = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_ARM: begin
          if (ready_ok_s) begin
            state_nxt_s = ST_RUN;
            enter_run_s = 1'b1;
          end else if (arm_expired_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ARM;
          end
        end
        ST_RUN: begin
          if (!ready_ok_s) begin
            state_nxt_s   = ST_DRAIN;
            enter_drain_s = 1'b1;
            link_loss_s   = 1'b1;
          end else if (run_cnt_r == 32'd0) begin
            state_nxt_s   = ST_DRAIN;
            enter_drain_s = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == 16'd0) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  assign count_en_s = (state_r == ST_RUN) || (state_r == ST_DRAIN);

  // Counter datapath: the link-loss penalty is applied on top of a same-cycle checker error.
  always_comb begin
    err_nxt_s       = err_count_r;
    word_nxt_s      = word_count_r;
    link_lost_nxt_s = link_lost_r;
    run_cnt_nxt_s   = run_cnt_r;
    drain_cnt_nxt_s = drain_cnt_r;
    if (clear_press_s) begin
      err_nxt_s       = ERR_ZERO;
      word_nxt_s      = 32'd0;
      link_lost_nxt_s = 1'b0;
      run_cnt_nxt_s   = 32'd0;
      drain_cnt_nxt_s = 16'd0;
    end else if (enter_arm_s) begin
      err_nxt_s       = ERR_ZERO;
      word_nxt_s      = 32'd0;
      link_lost_nxt_s = 1'b0;
    end else begin
      if (count_en_s && bus.chk_valid) begin
        word_nxt_s = sat_inc_word(word_count_r);
        if (bus.chk_error) begin
          err_nxt_s = sat_inc_err(err_count_r);
        end else begin
          err_nxt_s = err_count_r;
        end
      end else begin
        word_nxt_s = word_count_r;
      end
      if (link_loss_s) begin
        link_lost_nxt_s = 1'b1;
        err_nxt_s       = sat_inc_err(err_nxt_s);
      end else begin
        link_lost_nxt_s = link_lost_r;
      end
      if (enter_run_s) begin
        run_cnt_nxt_s = RUN_CYCLES - 32'd1;
      end else if ((state_r == ST_RUN) && (run_cnt_r != 32'd0)) begin
        run_cnt_nxt_s = run_cnt_r - 32'd1;
      end else begin
        run_cnt_nxt_s = run_cnt_r;
      end
      if (enter_drain_s) begin
        drain_cnt_nxt_s = DRAIN_CYCLES - 16'd1;
      end else if ((state_r == ST_DRAIN) && (drain_cnt_r != 16'd0)) begin
        drain_cnt_nxt_s = drain_cnt_r - 16'd1;
      end else begin
        drain_cnt_nxt_s = drain_cnt_r;
      end
    end
  end

  // State, counters and flags; outputs are registered from next-state so they align with state_r.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      err_count_r  <= ERR_ZERO;
      word_count_r <= 32'd0;
      link_lost_r  <= 1'b0;
      run_cnt_r    <= 32'd0;
      drain_cnt_r  <= 16'd0;
      gen_enable_r <= 1'b0;
      mon_active_r <= 1'b0;
      mon_done_r   <= 1'b0;
      mon_error_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      err_count_r  <= err_nxt_s;
      word_count_r <= word_nxt_s;
      link_lost_r  <= link_lost_nxt_s;
      run_cnt_r    <= run_cnt_nxt_s;
      drain_cnt_r  <= drain_cnt_nxt_s;
      gen_enable_r <= (state_nxt_s == ST_RUN);
      mon_active_r <= (state_nxt_s == ST_ARM) || (state_nxt_s == ST_RUN) ||
                      (state_nxt_s == ST_DRAIN);
      mon_done_r   <= (state_nxt_s == ST_DONE);
      mon_error_r  <= (err_nxt_s != ERR_ZERO) | link_lost_nxt_s | timeout_nxt_s;
    end
  end

  assign bus.gen_enable = gen_enable_r;
  assign bus.err_count  = err_count_r;
  assign bus.word_count = word_count_r;
  assign bus.status     = pack_status(sel_display_s, tx_data_ready_s, rx_data_ready_s,
                                      mon_active_r, mon_error_r, mon_done_r,
                                      tx_pma_ready_s, rx_pma_ready_s);

endmodule

// File: tb/tb_mon_status_ctrl.sv
// Scoreboard bench for mon_status_ctrl with shortened timing parameters.
module tb_mon_status_ctrl;
  import mon_status_pkg::*;

  logic clk = 1'b0;
  logic reset_n, pb_start_n, pb_clear_n, dip_sel_display;
  logic tx_pma_ready_in, rx_pma_ready_in, tx_data_ready_in, rx_data_ready_in;

  mon_status_ctrl_if #(.ERRW(4)) bus ();

  mon_status_ctrl #(
    .DEBOUNCE_CYCLES (20'd4),
    .RUN_CYCLES      (32'd100),
    .DRAIN_CYCLES    (16'd8),
`ifdef MON_TIMEOUT_EN
    .ARM_TIMEOUT     (32'd50),
`endif
    .ERRW            (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pb_start_n       (pb_start_n),
    .pb_clear_n       (pb_clear_n),
    .dip_sel_display  (dip_sel_display),
    .tx_pma_ready_in  (tx_pma_ready_in),
    .rx_pma_ready_in  (rx_pma_ready_in),
    .tx_data_ready_in (tx_data_ready_in),
    .rx_data_ready_in (rx_data_ready_in),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_val(t, obs, e);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic press_start(input int n);
    @(negedge clk);
    pb_start_n = 1'b0;
    wait_cycles(n);
    pb_start_n = 1'b1;
  endtask

  // Observe one run until mon_done, injecting checker errors and an optional rx ready drop.
  task automatic run_to_done(input int run_errs, input int run_gap, input int drain_errs,
                             input int drop_at, input int bound,
                             output int gen_cyc, output int drain_cyc, output int loss_lat,
                             output bit done_ok, output bit err_at_done);
    int left;
    bit loss_wait;
    gen_cyc = 0; drain_cyc = 0; loss_lat = 0; done_ok = 1'b0; err_at_done = 1'b0;
    left = run_errs; loss_wait = 1'b0;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      bus.chk_error = 1'b0;
      if (bus.status[STATUS_MON_DONE]) begin
        done_ok     = 1'b1;
        err_at_done = bus.status[STATUS_MON_ERROR];
        break;
      end
      if (loss_wait) begin
        loss_lat++;
        if (!bus.gen_enable) loss_wait = 1'b0;
      end
      if (bus.gen_enable) begin
        if (left > 0 && gen_cyc >= 10 && ((gen_cyc - 10) % run_gap) == 0) begin
          bus.chk_error = 1'b1;
          left--;
        end
        if (gen_cyc == drop_at) begin
          rx_pma_ready_in = 1'b0;
          loss_wait       = 1'b1;
        end
        gen_cyc++;
      end else if (gen_cyc > 0 && bus.status[STATUS_MON_ACTIVE]) begin
        if (drain_cyc < drain_errs) bus.chk_error = 1'b1;
        drain_cyc++;
      end
    end
    bus.chk_error = 1'b0;
  endtask

  task automatic run_and_score(input int run_errs, input int run_gap, input int drain_errs,
                               input int drop_at);
    int gen_cyc, drain_cyc, loss_lat;
    bit done_ok, err_at_done;
    run_to_done(run_errs, run_gap, drain_errs, drop_at, 400,
                gen_cyc, drain_cyc, loss_lat, done_ok, err_at_done);
    sb_pop(32'(done_ok));
    sb_pop(32'(gen_cyc));
    sb_pop(32'(drain_cyc));
    sb_pop(bus.word_count);
    sb_pop(32'(bus.err_count));
    sb_pop(32'(err_at_done));
    sb_pop(32'(bus.status[4:2]));
    if (drop_at >= 0) check_val("loss_latency_le3", 32'(loss_lat <= 3), 32'd1);
    @(negedge clk);
    check_val("error_stable_in_done", 32'(bus.status[STATUS_MON_ERROR]), 32'(err_at_done));
  endtask

  task automatic push_run(input int gen, input int words, input int errs);
    sb_push("done_reached", 32'd1);
    sb_push("gen_cycles", 32'(gen));
    sb_push("drain_cycles", 32'd8);
    sb_push("word_count", 32'(words));
    sb_push("err_count", 32'(errs > 15 ? 15 : errs));
    sb_push("error_at_done", 32'(errs != 0));
    sb_push("status_4_2_done", {29'd0, 2'b00, 1'b1} | (32'(errs != 0) << 1));
  endtask

  initial begin
    int pulses;
    int active_cyc;
    bit found;
    reset_n = 1'b0; pb_start_n = 1'b1; pb_clear_n = 1'b1; dip_sel_display = 1'b0;
    tx_pma_ready_in = 1'b0; rx_pma_ready_in = 1'b0;
    tx_data_ready_in = 1'b0; rx_data_ready_in = 1'b0;
    bus.chk_valid = 1'b0; bus.chk_error = 1'b0;

    wait_cycles(2);
    check_val("rst_status", 32'(bus.status), 32'h00);
    check_val("rst_gen_enable", 32'(bus.gen_enable), 32'd0);
    check_val("rst_err_count", 32'(bus.err_count), 32'd0);
    check_val("rst_word_count", bus.word_count, 32'd0);
    reset_n = 1'b1;

    // Clean run
    tx_pma_ready_in = 1'b1; rx_pma_ready_in = 1'b1; dip_sel_display = 1'b1;
    tx_data_ready_in = 1'b1; rx_data_ready_in = 1'b1; bus.chk_valid = 1'b1;
    wait_cycles(4);
    check_val("idle_status_passthru", 32'(bus.status), 32'hE3);
    push_run(100, 108, 0);
    press_start(6);
    run_and_score(0, 1, 0, -1);

    // Three errors in RUN plus one in DRAIN, then saturation
    wait_cycles(10);
    push_run(100, 108, 4);
    press_start(6);
    run_and_score(3, 10, 1, -1);
    wait_cycles(10);
    push_run(100, 108, 20);
    press_start(6);
    run_and_score(20, 2, 0, -1);

    // Clear from DONE
    wait_cycles(10);
    @(negedge clk); pb_clear_n = 1'b0;
    wait_cycles(6); pb_clear_n = 1'b1;
    wait_cycles(12);
    check_val("clear_status_4_2", 32'(bus.status[4:2]), 32'd0);
    check_val("clear_err_count", 32'(bus.err_count), 32'd0);
    check_val("clear_word_count", bus.word_count, 32'd0);

    // Bounce rejection, then one clean press (ARM held by missing TX PMA ready)
    tx_pma_ready_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pb_start_n = (i % 4) >= 2;
      if (dut.start_press_s) pulses++;
    end
    pb_start_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dut.start_press_s) pulses++;
    end
    check_val("bounce_pulses", 32'(pulses), 32'd0);
    check_val("bounce_stays_idle", 32'(bus.status[STATUS_MON_ACTIVE]), 32'd0);
    pulses = 0;
    pb_start_n = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 4) pb_start_n = 1'b1;
      if (dut.start_press_s) pulses++;
    end
    check_val("hold_pulses", 32'(pulses), 32'd1);
    check_val("hold_in_arm_4_2", 32'(bus.status[4:2]), 32'b100);

    // Link loss at RUN cycle 40: three more RUN cycles through the synchroniser
    push_run(43, 51, 1);
    tx_pma_ready_in = 1'b1;
    run_and_score(0, 1, 0, 40);
    rx_pma_ready_in = 1'b1;

    // Clear and start in the same cycle during RUN
    wait_cycles(10);
    press_start(6);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.gen_enable;
    end
    check_val("collision_run_reached", 32'(found), 32'd1);
    wait_cycles(20);
    @(negedge clk);
    pb_start_n = 1'b0; pb_clear_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (i == 5) begin pb_start_n = 1'b1; pb_clear_n = 1'b1; end
      found = dut.clear_press_s;
    end
    check_val("collision_start_same_cycle", 32'(dut.start_press_s), 32'd1);
    @(negedge clk);
    pb_start_n = 1'b1; pb_clear_n = 1'b1;
    check_val("collision_status_4_2", 32'(bus.status[4:2]), 32'd0);
    check_val("collision_err_count", 32'(bus.err_count), 32'd0);
    check_val("collision_word_count", bus.word_count, 32'd0);
    check_val("collision_gen_enable", 32'(bus.gen_enable), 32'd0);
    wait_cycles(10);
    check_val("collision_stays_idle", 32'(bus.status[STATUS_MON_ACTIVE]), 32'd0);

    // Reset while draining
    press_start(6);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = !bus.gen_enable && bus.status[STATUS_MON_ACTIVE] && bus.word_count > 32'd50;
    end
    check_val("drain_reached", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("rst_drain_status", 32'(bus.status), 32'h00);
    check_val("rst_drain_gen_enable", 32'(bus.gen_enable), 32'd0);
    check_val("rst_drain_err_count", 32'(bus.err_count), 32'd0);
    check_val("rst_drain_word_count", bus.word_count, 32'd0);
    wait_cycles(3);
    reset_n = 1'b1;

    // ARM without PMA ready
    tx_pma_ready_in = 1'b0;
    wait_cycles(8);
    check_val("arm_wait_status", 32'(bus.status), 32'hE1);
    press_start(6);
    active_cyc = 0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      found = bus.status[STATUS_MON_DONE];
      if (bus.status[STATUS_MON_ACTIVE]) active_cyc++;
    end
`ifdef MON_TIMEOUT_EN
    check_val("timeout_done", 32'(found), 32'd1);
    check_val("timeout_arm_cycles", 32'(active_cyc), 32'd50);
    check_val("timeout_error", 32'(bus.status[STATUS_MON_ERROR]), 32'd1);
`else
    check_val("no_timeout_done", 32'(found), 32'd0);
    check_val("no_timeout_active", 32'(bus.status[STATUS_MON_ACTIVE]), 32'd1);
`endif

    check_val("sb_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
